// File: rtl/instr_loader.sv
// Byte-stream instruction loader: packs little-endian bytes into 32-bit words and writes them to instruction memory.
// Latency: 5 cycles/word at full In_Valid; In_Ready low outside LOAD/CHECK. Optional checksum byte under LOADER_CHECKSUM_EN.
module instr_loader #(
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Start,
    input  logic [AW:0]   Num_Words,
    input  logic          In_Valid,
    input  logic [7:0]    In_Data,
    output logic          In_Ready,
    output logic          Imem_We,
    output logic [AW-1:0] Imem_Addr,
    output logic [31:0]   Imem_Wdata,
    output logic          Cpu_Reset,
    output logic          Busy,
    output logic          Done,
    output logic          Err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WRITE,
        S_DONE
`ifdef LOADER_CHECKSUM_EN
        ,
        S_CHECK,
        S_ERROR
`endif
    } state_t;

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    state_t        state_q, state_d;
    logic [1:0]    byte_q, byte_d;
    logic [AW-1:0] word_q, word_d;
    logic [AW:0]   num_q, num_d;
    logic [31:0]   data_q, data_d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]    sum_q, sum_d;
`endif
    logic          start_ok;
    logic          last_word;

    assign start_ok   = Start && (Num_Words != '0);
    assign last_word  = ({1'b0, word_q} + (AW+1)'(1)) == num_q;
    assign Imem_Addr  = word_q;
    assign Imem_Wdata = data_q;

    always_comb begin
        state_d   = state_q;
        byte_d    = byte_q;
        word_d    = word_q;
        num_d     = num_q;
        data_d    = data_q;
`ifdef LOADER_CHECKSUM_EN
        sum_d     = sum_q;
`endif
        In_Ready  = 1'b0;
        Imem_We   = 1'b0;
        Cpu_Reset = 1'b1;
        Busy      = 1'b0;
        Done      = 1'b0;
        Err       = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (state_q == S_DONE) begin
                    Done      = 1'b1;
                    Cpu_Reset = 1'b0;
                end
                // A fresh load (or reload from DONE) always restarts at word 0.
                if (start_ok) begin
                    state_d = S_LOAD;
                    byte_d  = '0;
                    word_d  = '0;
                    num_d   = (Num_Words > DEPTH_W) ? DEPTH_W : Num_Words;
`ifdef LOADER_CHECKSUM_EN
                    sum_d   = '0;
`endif
                end
            end
            S_LOAD: begin
                Busy     = 1'b1;
                In_Ready = 1'b1;
                if (In_Valid) begin
                    data_d[{byte_q, 3'b000} +: 8] = In_Data;
                    byte_d = byte_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                    sum_d  = sum_q + In_Data;
`endif
                    if (byte_q == 2'd3) begin
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                Busy    = 1'b1;
                Imem_We = 1'b1;
                word_d  = word_q + 1'b1;
                if (last_word) begin
`ifdef LOADER_CHECKSUM_EN
                    state_d = S_CHECK;
`else
                    state_d = S_DONE;
`endif
                end else begin
                    state_d = S_LOAD;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHECK: begin
                Busy     = 1'b1;
                In_Ready = 1'b1;
                if (In_Valid) begin
                    state_d = (In_Data == sum_q) ? S_DONE : S_ERROR;
                end
            end
            // Sticky until Reset; the processor is held in reset.
            S_ERROR: begin
                Err = 1'b1;
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q <= S_IDLE;
            byte_q  <= '0;
            word_q  <= '0;
            num_q   <= '0;
            data_q  <= '0;
`ifdef LOADER_CHECKSUM_EN
            sum_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            byte_q  <= byte_d;
            word_q  <= word_d;
            num_q   <= num_d;
            data_q  <= data_d;
`ifdef LOADER_CHECKSUM_EN
            sum_q   <= sum_d;
`endif
        end
    end

endmodule

// File: tb/tb_instr_loader.sv
// Scoreboarded bench for instr_loader: expected memory writes are queued by the stimulus and checked by a write monitor.
module tb_instr_loader;

    localparam int DEPTH = 32;
    localparam int AW    = 5;
`ifdef LOADER_CHECKSUM_EN
    localparam int CK = 1;
`else
    localparam int CK = 0;
`endif

    logic          Clk = 1'b0;
    logic          Reset;
    logic          Start;
    logic [AW:0]   Num_Words;
    logic          In_Valid;
    logic [7:0]    In_Data;
    logic          In_Ready;
    logic          Imem_We;
    logic [AW-1:0] Imem_Addr;
    logic [31:0]   Imem_Wdata;
    logic          Cpu_Reset;
    logic          Busy;
    logic          Done;
    logic          Err;

    instr_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Num_Words(Num_Words),
        .In_Valid(In_Valid), .In_Data(In_Data), .In_Ready(In_Ready),
        .Imem_We(Imem_We), .Imem_Addr(Imem_Addr), .Imem_Wdata(Imem_Wdata),
        .Cpu_Reset(Cpu_Reset), .Busy(Busy), .Done(Done), .Err(Err)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    wr_t  exp_q[$];
    int   n_checks  = 0;
    int   n_fail    = 0;
    int   n_writes  = 0;
    int   cyc       = 0;
    int   start_cyc = 0;
    logic [7:0] sum = 8'h00;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Write monitor: every Imem_We cycle must match the head of the scoreboard.
    always @(negedge Clk) begin
        if (Imem_We === 1'b1) begin
            wr_t e;
            n_writes++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: got %h@%0d expected none", Imem_Wdata, Imem_Addr);
            end else begin
                e = exp_q.pop_front();
                check("write_addr", 32'(Imem_Addr), 32'(e.addr));
                check("write_data", Imem_Wdata, e.data);
                check("write_in_ready", 32'(In_Ready), 32'd0);
            end
        end
    end

    task automatic push_exp(input int addr, input logic [31:0] data);
        wr_t e;
        e.addr = AW'(addr);
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic do_start(input int n);
        @(posedge Clk); #1;
        Start     = 1'b1;
        Num_Words = (AW+1)'(n);
        @(posedge Clk); #1;
        start_cyc = cyc;
        Start     = 1'b0;
        sum       = 8'h00;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit ok;
        ok       = 1'b0;
        In_Valid = 1'b1;
        In_Data  = b;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge Clk);
            ok = (In_Ready === 1'b1);
            @(posedge Clk); #1;
        end
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL byte_timeout: got no In_Ready expected ready within 20 cycles");
        end
        sum = sum + b;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    endtask

    // Completes a load: with checksum, sends the running sum and lands in DONE.
    task automatic finish_load();
`ifdef LOADER_CHECKSUM_EN
        send_byte(sum);
        In_Valid = 1'b0;
`else
        In_Valid = 1'b0;
        @(posedge Clk); #1;
`endif
    endtask

    task automatic pulse_reset();
        In_Valid = 1'b0;
        Reset    = 1'b0;
        @(posedge Clk); #1;
        Reset    = 1'b1;
    endtask

    initial begin
        int wb;
        Reset = 1'b0; Start = 1'b0; Num_Words = '0; In_Valid = 1'b0; In_Data = 8'h00;
        @(posedge Clk); #1;
        Reset = 1'b1;
        check("rst_cpu_reset", 32'(Cpu_Reset), 32'd1);
        check("rst_in_ready",  32'(In_Ready),  32'd0);
        check("rst_we",        32'(Imem_We),   32'd0);
        check("rst_addr",      32'(Imem_Addr), 32'd0);
        check("rst_wdata",     Imem_Wdata,     32'd0);
        check("rst_busy",      32'(Busy),      32'd0);
        check("rst_done",      32'(Done),      32'd0);
        check("rst_err",       32'(Err),       32'd0);

        // Two words, continuous stream.
        push_exp(0, 32'hE3A00013);
        push_exp(1, 32'hE0811001);
        do_start(2);
        check("load_busy", 32'(Busy), 32'd1);
        send_word(32'hE3A00013);
        send_word(32'hE0811001);
        finish_load();
        check("t1_done",      32'(Done),        32'd1);
        check("t1_cpu_reset", 32'(Cpu_Reset),   32'd0);
        check("t1_latency",   32'(cyc - start_cyc), 32'(10 + CK));

        // Reload from DONE with a 3-cycle In_Valid gap after byte 2.
        push_exp(0, 32'hE3A00013);
        push_exp(1, 32'hE0811001);
        do_start(2);
        check("reload_cpu_reset", 32'(Cpu_Reset), 32'd1);
        check("reload_busy",      32'(Busy),      32'd1);
        send_byte(8'h13);
        send_byte(8'h00);
        In_Valid = 1'b0;
        repeat (3) begin @(posedge Clk); #1; end
        send_byte(8'hA0);
        send_byte(8'hE3);
        send_word(32'hE0811001);
        finish_load();
        check("t2_done",    32'(Done), 32'd1);
        check("t2_latency", 32'(cyc - start_cyc), 32'(13 + CK));

        // Zero-length start is ignored, both in DONE and in IDLE.
        do_start(0);
        check("zero_done_stays", 32'(Done), 32'd1);
        check("zero_done_busy",  32'(Busy), 32'd0);
        pulse_reset();
        do_start(0);
        check("zero_idle_busy",  32'(Busy),      32'd0);
        check("zero_idle_ready", 32'(In_Ready),  32'd0);
        check("zero_idle_cpu",   32'(Cpu_Reset), 32'd1);

        // Oversized request clamps to DEPTH words.
        for (int i = 0; i < DEPTH; i++) push_exp(i, {8'(i), 8'(i ^ 8'hFF), 8'(i + 8'h40), 8'hC3});
        wb = n_writes;
        do_start(40);
        for (int i = 0; i < DEPTH; i++) send_word({8'(i), 8'(i ^ 8'hFF), 8'(i + 8'h40), 8'hC3});
        finish_load();
        check("clamp_done",   32'(Done), 32'd1);
        check("clamp_writes", 32'(n_writes - wb), 32'(DEPTH));

        // Reset after 5 bytes aborts; a fresh 1-word load follows.
        pulse_reset();
        push_exp(0, 32'hE3A00013);
        do_start(2);
        send_word(32'hE3A00013);
        send_byte(8'h01);
        pulse_reset();
        check("abort_busy", 32'(Busy), 32'd0);
        check("abort_cpu",  32'(Cpu_Reset), 32'd1);
        push_exp(0, 32'h11223344);
        wb = n_writes;
        do_start(1);
        send_word(32'h11223344);
        finish_load();
        check("abort_done",   32'(Done), 32'd1);
        check("abort_writes", 32'(n_writes - wb), 32'd1);

`ifdef LOADER_CHECKSUM_EN
        pulse_reset();
        push_exp(0, 32'h04030201);
        do_start(1);
        send_word(32'h04030201);
        send_byte(8'h0A);
        In_Valid = 1'b0;
        check("ck_good_done", 32'(Done), 32'd1);
        check("ck_good_err",  32'(Err),  32'd0);
        pulse_reset();
        push_exp(0, 32'h04030201);
        do_start(1);
        send_word(32'h04030201);
        send_byte(8'h0B);
        In_Valid = 1'b0;
        check("ck_bad_err",  32'(Err),       32'd1);
        check("ck_bad_done", 32'(Done),      32'd0);
        check("ck_bad_cpu",  32'(Cpu_Reset), 32'd1);
        do_start(1);
        check("ck_err_sticky", 32'(Err),  32'd1);
        check("ck_err_busy",   32'(Busy), 32'd0);
`else
        check("no_ck_err", 32'(Err), 32'd0);
`endif

        repeat (3) @(posedge Clk);
        #1;
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_loader.md
INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 SHALL have parameter DEPTH, default 32, meaning number of 32-bit instruction-memory words.
REQ-002 SHALL have parameter AW, default 5, meaning instruction-memory address width (2^AW >= DEPTH).
REQ-003 SHALL have port Clk  input  1  the only clock; all state updates on its rising edge.
REQ-004 SHALL have port Reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have port Start  input  1  one-cycle request to begin a load.
REQ-006 SHALL have port Num_Words  input  AW+1  number of words to load, sampled when Start is accepted.
REQ-007 SHALL have port In_Valid  input  1  byte-stream valid.
REQ-008 SHALL have port In_Data  input  8  byte-stream data.
REQ-009 SHALL have port In_Ready  output  1  byte-stream ready.
REQ-010 SHALL have port Imem_We  output  1  instruction-memory write enable.
REQ-011 SHALL have port Imem_Addr  output  AW  instruction-memory word address.
REQ-012 SHALL have port Imem_Wdata  output  32  instruction-memory write data.
REQ-013 SHALL have port Cpu_Reset  output  1  active-high reset driven to the processor's Reset input.
REQ-014 SHALL have port Busy  output  1  high in LOAD, WRITE and CHECK.
REQ-015 SHALL have port Done  output  1  high in DONE.
REQ-016 SHALL have port Err  output  1  high in ERROR.

Function
REQ-017 SHALL implement the states IDLE, LOAD, WRITE, CHECK, DONE and ERROR.
REQ-018 SHALL move IDLE->LOAD on Start with Num_Words!=0; SHALL ignore Start with Num_Words==0.
REQ-019 SHALL clamp a Num_Words value greater than DEPTH to DEPTH.
REQ-020 SHALL assert In_Ready only in LOAD and CHECK; a byte transfers on a cycle where In_Valid and In_Ready are both 1.
REQ-021 SHALL assemble bytes little-endian: the first byte goes to Wdata[7:0] and the fourth byte to Wdata[31:24].
REQ-022 SHALL go LOAD->WRITE on the 4th byte transfer.
REQ-023 SHALL hold Imem_We=1 for exactly the one WRITE cycle, with Imem_Addr = word index (starting at 0) and In_Ready=0.
REQ-024 SHALL go WRITE->LOAD if words remain; after the last word, WRITE->DONE (or WRITE->CHECK per REQ-033).
REQ-025 SHALL drive Cpu_Reset=1 in IDLE, LOAD, WRITE, CHECK and ERROR, and Cpu_Reset=0 only in DONE.
REQ-026 SHALL go DONE->LOAD on Start (reload), which re-asserts Cpu_Reset the next cycle and restarts the address at 0.
REQ-027 SHALL ignore Start while Busy=1.
REQ-028 SHALL leave ERROR only through Reset.
REQ-029 SHALL reach WRITE no earlier than 4 cycles after LOAD entry (throughput: 5 cycles/word at full In_Valid).
REQ-030 SHALL NOT lose or duplicate a byte when In_Valid gaps occur mid-word.

Reset
REQ-031 SHALL, while Reset==0 at a clock edge, enter IDLE, clear the byte and word counters and the data register, and drive In_Ready=0, Imem_We=0, Imem_Addr=0, Imem_Wdata=0, Cpu_Reset=1, Busy=0, Done=0, Err=0.
REQ-032 SHALL, when Reset is asserted mid-load, abort and write nothing further; already-written memory words are not cleared.

Configuration
REQ-033 SHALL compile the checksum feature under macro LOADER_CHECKSUM_EN; when defined: keep an 8-bit modular sum of all payload bytes, go WRITE->CHECK after the last word, accept one checksum byte in CHECK, go to DONE if it equals the sum, otherwise go to ERROR.
REQ-034 SHALL, without LOADER_CHECKSUM_EN, omit CHECK and ERROR, drive Err=0 constantly, and go WRITE->DONE after the last word.

Verification
REQ-035 SHALL verify: Reset=0 for 1 cycle -> Cpu_Reset=1, all other outputs 0, state IDLE.
REQ-036 SHALL verify: Start, Num_Words=2, bytes 13,00,A0,E3,01,10,81,E0 continuous -> writes E3A00013@0 and E0811001@1, each with a one-cycle Imem_We; Done=1 and Cpu_Reset=0 on the cycle after the second write.
REQ-037 SHALL verify: the same load with In_Valid low for 3 cycles after byte 2 -> identical writes, completion delayed by 3 cycles.
REQ-038 SHALL verify: Num_Words=0 with Start -> stays IDLE; Num_Words=40 with DEPTH=32 -> exactly 32 writes, addresses 0..31.
REQ-039 SHALL verify: Reset=0 after 5 bytes, then a new load of 1 word 11223344 -> a single write of 11223344@0, then Done.
REQ-040 SHALL verify, with LOADER_CHECKSUM_EN: 1 word of bytes 01,02,03,04 then checksum 0A -> Done=1; checksum 0B -> Err=1 and Cpu_Reset stays 1.
